// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I encoding constants: format codes, immediate ranges, opcodes.
// Imported by the encoder and its immediate checker; also matches the CPU control unit.
package instruction_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100,
        FMT_R = 3'b101
    } fmt_e;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048574;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/instruction_encoder_immediate_check.sv
// Purpose: flags immediates that do not fit their format, misaligned branch/jump offsets, illegal formats.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module instruction_encoder_immediate_check
    import instruction_encoder_pkg::*;
(
    input  logic [2:0]  format,
    input  logic [31:0] immediate,
    output logic        error
);

    logic signed [31:0] simm;
    assign simm = $signed(immediate);

    always_comb begin
        error = 1'b0;
        case (format)
            FMT_I, FMT_S: error = (simm < IMM12_MIN) || (simm > IMM12_MAX);
            FMT_B:        error = (simm < IMM13_MIN) || (simm > IMM13_MAX) || immediate[0];
            FMT_J:        error = (simm < IMM21_MIN) || (simm > IMM21_MAX) || immediate[0];
            FMT_U:        error = (immediate[11:0] != 12'd0);
            FMT_R:        error = 1'b0;
            default:      error = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Purpose: packs RV32I fields + immediate into an address-tagged instruction word with error flagging.
// Latency: 1 cycle, single output register.
// Backpressure: in_ready = !out_valid | out_ready; outputs hold while out_valid & !out_ready.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] START_ADDRESS = '0,
    parameter int                       COUNT_WIDTH   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               format,
    input  logic [6:0]               opcode,
    input  logic [4:0]               rd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [31:0]              immediate,
    input  logic                     address_load,
    input  logic [ADDRESS_WIDTH-1:0] address_value,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instruction,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    output logic                     out_error,
    output logic [COUNT_WIDTH-1:0]   error_count
);

    logic                     accept;
    logic                     imm_error;
    logic [31:0]              packed_word;
    logic [ADDRESS_WIDTH-1:0] aligned_value;
    logic [ADDRESS_WIDTH-1:0] next_address;
    logic [ADDRESS_WIDTH-1:0] tag_address;

    assign in_ready      = !out_valid || out_ready;
    assign accept        = in_valid && in_ready;
    assign aligned_value = address_value & ~ADDRESS_WIDTH'(3);
    assign tag_address   = address_load ? aligned_value : next_address;

    instruction_encoder_immediate_check u_immediate_check (
        .format    (format),
        .immediate (immediate),
        .error     (imm_error)
    );

    always_comb begin
        packed_word = '0;
        case (format)
            FMT_I: packed_word = {immediate[11:0], rs1, funct3, rd, opcode};
            FMT_S: packed_word = {immediate[11:5], rs2, rs1, funct3, immediate[4:0], opcode};
            FMT_B: packed_word = {immediate[12], immediate[10:5], rs2, rs1, funct3,
                                  immediate[4:1], immediate[11], opcode};
            FMT_J: packed_word = {immediate[20], immediate[10:1], immediate[11],
                                  immediate[19:12], rd, opcode};
            FMT_U: packed_word = {immediate[31:12], rd, opcode};
            FMT_R: packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
            default: packed_word = '0;
        endcase
    end

    // Output stage: loads on accept, otherwise only out_valid may fall when drained.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_address     <= START_ADDRESS;
            out_error       <= 1'b0;
            error_count     <= '0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            out_instruction <= packed_word;
            out_address     <= tag_address;
            out_error       <= imm_error;
            if (imm_error && (error_count != '1)) begin
                error_count <= error_count + COUNT_WIDTH'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A load without an accept retargets the next word; with an accept it tags this word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            next_address <= START_ADDRESS;
        end else if (accept) begin
            next_address <= tag_address + ADDRESS_WIDTH'(4);
        end else if (address_load) begin
            next_address <= aligned_value;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: packing, round-trip through an immediate extender,
// backpressure, errors with saturation, address tagging and asynchronous reset.
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  format;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] immediate;
    logic        address_load;
    logic [31:0] address_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_address;
    logic        out_error;
    logic [7:0]  error_count;
    logic        sat_in_ready, sat_out_valid, sat_out_error;
    logic [31:0] sat_out_instruction, sat_out_address;
    logic [1:0]  sat_error_count;

    int checks = 0;
    int errors = 0;

    instruction_encoder dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .format(format), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .immediate(immediate),
        .address_load(address_load), .address_value(address_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
        .out_address(out_address), .out_error(out_error), .error_count(error_count)
    );

    instruction_encoder #(.COUNT_WIDTH(2)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready),
        .format(format), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .immediate(immediate),
        .address_load(address_load), .address_value(address_value),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_instruction(sat_out_instruction),
        .out_address(sat_out_address), .out_error(sat_out_error), .error_count(sat_error_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_bundle(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        format = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; immediate = imm; in_valid = 1'b1;
    endtask

    // Reference immediate extender as used by the CPU decode stage.
    function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] w);
        case (f)
            FMT_I:   return {{20{w[31]}}, w[31:20]};
            FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    logic [2:0]  rt_fmt  [4]  = '{FMT_I, FMT_S, FMT_B, FMT_J};
    logic [6:0]  rt_op   [4]  = '{OP_IMM, OP_STORE, OP_BRANCH, OP_JAL};
    logic [31:0] rt_imm  [4][5] = '{
        '{32'd0, 32'd1, -32'sd2, -32'sd2048,    32'd2047},
        '{32'd0, 32'd1, -32'sd2, -32'sd2048,    32'd2047},
        '{32'd0, 32'd2, -32'sd2, -32'sd4096,    32'd4094},
        '{32'd0, 32'd2, -32'sd2, -32'sd1048576, 32'd1048574}
    };
    logic [31:0] exp_addr;

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        address_load = 1'b0; address_value = '0;
        set_bundle(FMT_I, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b0;
        tick; tick;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_instruction", out_instruction, 0);
        check("reset_out_address", out_address, 0);
        check("reset_out_error", out_error, 0);
        check("reset_error_count", error_count, 0);
        check("reset_in_ready", in_ready, 1);
        reset = 1'b1;
        tick;

        // addi x1, x0, 5
        set_bundle(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick;
        check("addi_word", out_instruction, 32'h00500093);
        check("addi_addr", out_address, 0);
        check("addi_valid", out_valid, 1);
        check("addi_error", out_error, 0);
        exp_addr = 32'd4;

        // Back-to-back round trips
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 5; k++) begin
                set_bundle(rt_fmt[f], rt_op[f], 5'd7, 5'd12, 5'd21, 3'd2, 7'd0, rt_imm[f][k]);
                tick;
                check($sformatf("roundtrip_f%0d_k%0d", f, k), extend(rt_fmt[f], out_instruction), rt_imm[f][k]);
                check($sformatf("roundtrip_err_f%0d_k%0d", f, k), out_error, 0);
                check($sformatf("roundtrip_addr_f%0d_k%0d", f, k), out_address, exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
        end

        // add x3, x1, x2 and lui x5, 0x12345
        set_bundle(FMT_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFF);
        tick;
        check("r_add_word", out_instruction, 32'h002081B3);
        check("r_add_error", out_error, 0);
        set_bundle(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        tick;
        check("u_lui_word", out_instruction, 32'h123452B7);
        check("count_before_errors", error_count, 0);

        // Erroneous bundles
        set_bundle(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        tick;
        check("err_i_2048", out_error, 1);
        check("err_i_word", out_instruction, 32'h80000093);
        set_bundle(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        tick;
        check("err_b_odd", out_error, 1);
        set_bundle(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001);
        tick;
        check("err_u_low", out_error, 1);
        check("sat_count_3", sat_error_count, 3);
        set_bundle(3'b111, OP_IMM, 5'd1, 5'd1, 5'd1, 3'd7, 7'h7F, 32'd0);
        tick;
        check("err_fmt_illegal", out_error, 1);
        check("err_fmt_word", out_instruction, 0);
        check("err_count_4", error_count, 4);
        check("sat_count_held", sat_error_count, 3);
        set_bundle(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096);
        tick;
        check("err_b_range", out_error, 1);
        set_bundle(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576);
        tick;
        check("err_j_range", out_error, 1);
        check("err_count_6", error_count, 6);
        set_bundle(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
        tick;
        check("legal_clears_error", out_error, 0);
        check("legal_keeps_count", error_count, 6);

        // Address load with an accept, wrap, then load without an accept
        address_load = 1'b1; address_value = 32'hFFFF_FFFC;
        set_bundle(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        tick;
        address_load = 1'b0;
        check("load_tag", out_address, 32'hFFFF_FFFC);
        tick;
        check("wrap_tag", out_address, 0);
        in_valid = 1'b0; address_load = 1'b1; address_value = 32'h103;
        tick;
        address_load = 1'b0;
        check("idle_load_no_word", out_valid, 0);
        set_bundle(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        tick;
        check("aligned_tag", out_address, 32'h100);

        // Reset while a word is stalled
        out_ready = 1'b0;
        tick;
        check("stall_before_reset", out_valid, 1);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_count", error_count, 0);
        check("async_reset_addr", out_address, 0);
        tick;
        reset = 1'b1;
        tick;

        // Backpressure: first word stalls 3 cycles, then 4 words flow out
        set_bundle(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick;
        set_bundle(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
            check($sformatf("bp_word_c%0d", c), out_instruction, 32'h00000093);
            check($sformatf("bp_addr_c%0d", c), out_address, 0);
            tick;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        check("bp_count_after_reset", error_count, 0);
        for (int k = 1; k < 4; k++) begin
            tick;
            check($sformatf("bp_word%0d", k), out_instruction, (32'(k) << 20) | 32'h93);
            check($sformatf("bp_addr%0d", k), out_address, 32'(k) * 4);
            if (k < 3) immediate = 32'(k + 1);
            else in_valid = 1'b0;
        end
        tick;
        check("bp_drained", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
